// File: rtl/ed25519_scalar_mult_ctrl.sv
// Bit-serial double-and-add sequencer computing R = k*P through external point double/add units.
// Define ED25519_SMUL_CONST_TIME_EN to run the add step on every bit (constant-time schedule).
module ed25519_scalar_mult_ctrl #(
    parameter int SCALAR_W = 253,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SCALAR_W-1:0] scalar,
    input  logic [254:0]        P_X,
    input  logic [254:0]        P_Y,
    input  logic [254:0]        P_Z,
    input  logic [254:0]        P_T,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [254:0]        R_X,
    output logic [254:0]        R_Y,
    output logic [254:0]        R_Z,
    output logic [254:0]        R_T,
    output logic [31:0]         cycles,
    output logic                dbl_start,
    output logic [254:0]        dbl_X,
    output logic [254:0]        dbl_Y,
    output logic [254:0]        dbl_Z,
    output logic [254:0]        dbl_T,
    input  logic                dbl_done,
    input  logic [254:0]        dbl_RX,
    input  logic [254:0]        dbl_RY,
    input  logic [254:0]        dbl_RZ,
    input  logic [254:0]        dbl_RT,
    output logic                add_start,
    output logic [254:0]        add_P1_X,
    output logic [254:0]        add_P1_Y,
    output logic [254:0]        add_P1_Z,
    output logic [254:0]        add_P1_T,
    output logic [254:0]        add_P2_X,
    output logic [254:0]        add_P2_Y,
    output logic [254:0]        add_P2_Z,
    output logic [254:0]        add_P2_T,
    input  logic                add_done,
    input  logic [254:0]        add_P3_X,
    input  logic [254:0]        add_P3_Y,
    input  logic [254:0]        add_P3_Z,
    input  logic [254:0]        add_P3_T
);
    localparam int IDX_W = (SCALAR_W > 1) ? $clog2(SCALAR_W) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DBL_REQ,
        DBL_WAIT,
        ADD_REQ,
        ADD_WAIT,
        NEXT
    } state_t;

    state_t              state;
    logic [SCALAR_W-1:0] scalar_q;
    logic [IDX_W-1:0]    idx;
    logic [WD_W-1:0]     wd;
    logic [254:0]        acc_x, acc_y, acc_z, acc_t;
    logic [254:0]        p_x, p_y, p_z, p_t;
    logic                bit_set;
    logic [254:0]        sel_x, sel_y, sel_z, sel_t;

    // Unit operands come straight from the accumulator and latched P registers.
    assign dbl_X    = acc_x;
    assign dbl_Y    = acc_y;
    assign dbl_Z    = acc_z;
    assign dbl_T    = acc_t;
    assign add_P1_X = acc_x;
    assign add_P1_Y = acc_y;
    assign add_P1_Z = acc_z;
    assign add_P1_T = acc_t;
    assign add_P2_X = p_x;
    assign add_P2_Y = p_y;
    assign add_P2_Z = p_z;
    assign add_P2_T = p_t;

    // The add result is kept only for a set bit; a dummy add leaves acc untouched.
    always_comb begin
        bit_set = scalar_q[idx];
        sel_x   = bit_set ? add_P3_X : acc_x;
        sel_y   = bit_set ? add_P3_Y : acc_y;
        sel_z   = bit_set ? add_P3_Z : acc_z;
        sel_t   = bit_set ? add_P3_T : acc_t;
    end

    // NOTE: every register in this block uses non-blocking assignment so all
    // state updates see the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            scalar_q  <= '0;
            idx       <= '0;
            wd        <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            acc_z     <= '0;
            acc_t     <= '0;
            p_x       <= '0;
            p_y       <= '0;
            p_z       <= '0;
            p_t       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            R_X       <= '0;
            R_Y       <= '0;
            R_Z       <= '0;
            R_T       <= '0;
            cycles    <= '0;
            dbl_start <= 1'b0;
            add_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        scalar_q  <= scalar;
                        p_x       <= P_X;
                        p_y       <= P_Y;
                        p_z       <= P_Z;
                        p_t       <= P_T;
                        acc_x     <= '0;
                        acc_y     <= 255'd1;
                        acc_z     <= 255'd1;
                        acc_t     <= '0;
                        idx       <= IDX_W'(SCALAR_W - 1);
                        wd        <= '0;
                        cycles    <= 32'd1;  // includes the DBL_REQ cycle being entered
                        busy      <= 1'b1;
                        dbl_start <= 1'b1;
                        state     <= DBL_REQ;
                    end
                end
                DBL_REQ: begin
                    dbl_start <= 1'b0;
                    wd        <= '0;
                    state     <= DBL_WAIT;
                end
                DBL_WAIT: begin
                    if (dbl_done) begin
                        acc_x <= dbl_RX;
                        acc_y <= dbl_RY;
                        acc_z <= dbl_RZ;
                        acc_t <= dbl_RT;
`ifdef ED25519_SMUL_CONST_TIME_EN
                        add_start <= 1'b1;
                        state     <= ADD_REQ;
`else
                        if (bit_set) begin
                            add_start <= 1'b1;
                            state     <= ADD_REQ;
                        end else begin
                            state <= NEXT;
                            if (idx == '0) begin
                                done <= 1'b1;
                                R_X  <= dbl_RX;
                                R_Y  <= dbl_RY;
                                R_Z  <= dbl_RZ;
                                R_T  <= dbl_RT;
                            end
                        end
`endif
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= NEXT;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                ADD_REQ: begin
                    add_start <= 1'b0;
                    wd        <= '0;
                    state     <= ADD_WAIT;
                end
                ADD_WAIT: begin
                    if (add_done) begin
                        acc_x <= sel_x;
                        acc_y <= sel_y;
                        acc_z <= sel_z;
                        acc_t <= sel_t;
                        state <= NEXT;
                        if (idx == '0) begin
                            done <= 1'b1;
                            R_X  <= sel_x;
                            R_Y  <= sel_y;
                            R_Z  <= sel_z;
                            R_T  <= sel_t;
                        end
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= NEXT;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                NEXT: begin
                    // done is already visible here on the final bit or after a watchdog abort.
                    if (done) begin
                        done  <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx       <= idx - IDX_W'(1);
                        dbl_start <= 1'b1;
                        state     <= DBL_REQ;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state != IDLE && !(state == NEXT && done) && cycles != '1)
                cycles <= cycles + 32'd1;
        end
    end
endmodule

// File: tb/tb_ed25519_scalar_mult_ctrl.sv
// Scoreboard bench for ed25519_scalar_mult_ctrl with latency-programmable mock point units.
module tb_ed25519_scalar_mult_ctrl;
    typedef struct packed {
        logic [254:0] x;
        logic [254:0] y;
        logic [254:0] z;
        logic [254:0] t;
    } pt_t;

    typedef struct {
        pt_t  r;
        logic err;
        int   cycles;
        int   n_dbl;
        int   n_add;
        int   gap;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [252:0] scalar;
    logic [254:0] P_X, P_Y, P_Z, P_T;
    logic         busy, done, err;
    logic [254:0] R_X, R_Y, R_Z, R_T;
    logic [31:0]  cycles;
    logic         dbl_start, dbl_done;
    logic [254:0] dbl_X, dbl_Y, dbl_Z, dbl_T, dbl_RX, dbl_RY, dbl_RZ, dbl_RT;
    logic         add_start, add_done;
    logic [254:0] add_P1_X, add_P1_Y, add_P1_Z, add_P1_T;
    logic [254:0] add_P2_X, add_P2_Y, add_P2_Z, add_P2_T;
    logic [254:0] add_P3_X, add_P3_Y, add_P3_Z, add_P3_T;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_dbl = 0, n_add = 0, n_done = 0, last_dbl_cyc = 0;
    int   lat_dbl = 3, lat_add = 2;
    logic dbl_hang = 1'b0, stale_add = 1'b0, chk_busy = 1'b0;
    pt_t  last_r = '0;
    exp_t sb[$];

    ed25519_scalar_mult_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .scalar(scalar),
        .P_X(P_X), .P_Y(P_Y), .P_Z(P_Z), .P_T(P_T),
        .busy(busy), .done(done), .err(err),
        .R_X(R_X), .R_Y(R_Y), .R_Z(R_Z), .R_T(R_T), .cycles(cycles),
        .dbl_start(dbl_start), .dbl_X(dbl_X), .dbl_Y(dbl_Y), .dbl_Z(dbl_Z), .dbl_T(dbl_T),
        .dbl_done(dbl_done), .dbl_RX(dbl_RX), .dbl_RY(dbl_RY), .dbl_RZ(dbl_RZ), .dbl_RT(dbl_RT),
        .add_start(add_start),
        .add_P1_X(add_P1_X), .add_P1_Y(add_P1_Y), .add_P1_Z(add_P1_Z), .add_P1_T(add_P1_T),
        .add_P2_X(add_P2_X), .add_P2_Y(add_P2_Y), .add_P2_Z(add_P2_Z), .add_P2_T(add_P2_T),
        .add_done(add_done),
        .add_P3_X(add_P3_X), .add_P3_Y(add_P3_Y), .add_P3_Z(add_P3_Z), .add_P3_T(add_P3_T)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [254:0] act, input logic [254:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Mock point operations: arbitrary but deterministic, and doubling fixes the identity.
    function automatic pt_t mdbl(input pt_t a);
        pt_t r;
        r.x = a.x + a.x;
        r.y = a.y ^ (a.x << 3);
        r.z = a.z + (a.t >> 1);
        r.t = a.t + a.t + a.x;
        return r;
    endfunction

    function automatic pt_t madd(input pt_t a, input pt_t b);
        pt_t r;
        r.x = a.x + b.x;
        r.y = a.y ^ b.z;
        r.z = a.z + b.y;
        r.t = a.t + (a.x ^ b.t);
        return r;
    endfunction

    function automatic pt_t model(input logic [252:0] k, input pt_t p);
        pt_t acc;
        acc = {255'd0, 255'd1, 255'd1, 255'd0};
        for (int i = 252; i >= 0; i--) begin
            acc = mdbl(acc);
            if (k[i]) acc = madd(acc, p);
        end
        return acc;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Mock doubler: responds lat_dbl cycles after dbl_start unless hung or reset intervenes.
    initial begin
        pt_t  res;
        logic ab;
        dbl_done = 1'b0;
        {dbl_RX, dbl_RY, dbl_RZ, dbl_RT} = '0;
        forever begin
            @(negedge clk);
            if (dbl_start && !dbl_hang) begin
                res = mdbl({dbl_X, dbl_Y, dbl_Z, dbl_T});
                ab  = 1'b0;
                for (int i = 0; i < lat_dbl; i++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                if (!ab) begin
                    {dbl_RX, dbl_RY, dbl_RZ, dbl_RT} = res;
                    dbl_done = 1'b1;
                    @(negedge clk);
                    dbl_done = 1'b0;
                end
            end
        end
    end

    // Mock adder, which can also inject one unsolicited add_done.
    initial begin
        pt_t  res;
        logic ab;
        add_done = 1'b0;
        {add_P3_X, add_P3_Y, add_P3_Z, add_P3_T} = '0;
        forever begin
            @(negedge clk);
            if (stale_add) begin
                {add_P3_X, add_P3_Y, add_P3_Z, add_P3_T} = {4{rand256()}};
                add_done = 1'b1;
                @(negedge clk);
                add_done  = 1'b0;
                stale_add = 1'b0;
            end else if (add_start) begin
                res = madd({add_P1_X, add_P1_Y, add_P1_Z, add_P1_T},
                           {add_P2_X, add_P2_Y, add_P2_Z, add_P2_T});
                ab  = 1'b0;
                for (int i = 0; i < lat_add; i++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                if (!ab) begin
                    {add_P3_X, add_P3_Y, add_P3_Z, add_P3_T} = res;
                    add_done = 1'b1;
                    @(negedge clk);
                    add_done = 1'b0;
                end
            end
        end
    end

    // Output monitor: counts unit starts and scores every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_busy) begin
                check("busy_after_done", 255'(busy), 255'(0));
                chk_busy = 1'b0;
            end
            if (dbl_start) begin
                n_dbl++;
                last_dbl_cyc = cyc;
            end
            if (add_start) n_add++;
            if (done) begin
                n_done++;
                chk_busy = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_done", 255'(done), 255'(0));
                end else begin
                    e = sb.pop_front();
                    check("err", 255'(err), 255'(e.err));
                    check("R_X", R_X, e.r.x);
                    check("R_Y", R_Y, e.r.y);
                    check("R_Z", R_Z, e.r.z);
                    check("R_T", R_T, e.r.t);
                    check("cycles", 255'(cycles), 255'(e.cycles));
                    check("dbl_start_count", 255'(n_dbl), 255'(e.n_dbl));
                    check("add_start_count", 255'(n_add), 255'(e.n_add));
                    if (e.gap >= 0)
                        check("timeout_gap", 255'(cyc - last_dbl_cyc), 255'(e.gap));
                end
            end
        end
    end

    task automatic launch(input logic [252:0] k, input logic expect_timeout);
        exp_t e;
        int   pop;
        pop = $countones(k);
        if (expect_timeout) begin
            e.r = last_r;
            e.err = 1'b1;
            e.cycles = 257;
            e.n_dbl = 1;
            e.n_add = 0;
            e.gap = 256;
        end else begin
            e.r = model(k, {P_X, P_Y, P_Z, P_T});
            e.err = 1'b0;
            e.n_dbl = 253;
            e.gap = -1;
`ifdef ED25519_SMUL_CONST_TIME_EN
            e.cycles = 253 * (3 + lat_dbl + lat_add);
            e.n_add = 253;
`else
            e.cycles = 253 * (2 + lat_dbl) + pop * (1 + lat_add);
            e.n_add = pop;
`endif
            last_r = e.r;
        end
        @(negedge clk);
        scalar = k;
        start = 1'b1;
        n_dbl = 0;
        n_add = 0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("done_seen", 255'(sb.size()), 255'(0));
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [252:0] k;
        int           done_before;
        rst = 1'b1;
        start = 1'b0;
        scalar = '0;
        {P_X, P_Y, P_Z, P_T} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 255'(busy), 255'(0));
        check("rst_done", 255'(done), 255'(0));
        check("rst_err", 255'(err), 255'(0));
        check("rst_R_X", R_X, '0);
        check("rst_R_Y", R_Y, '0);
        check("rst_R_Z", R_Z, '0);
        check("rst_R_T", R_T, '0);
        check("rst_cycles", 255'(cycles), 255'(0));
        check("rst_dbl_start", 255'(dbl_start), 255'(0));
        check("rst_add_start", 255'(add_start), 255'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        {P_X, P_Y, P_Z, P_T} = {rand256(), rand256(), rand256(), rand256()};

        lat_dbl = 3; lat_add = 2;
        launch(253'd0, 1'b0);
        wait_idle(20000);

        lat_dbl = 1; lat_add = 1;
        launch(253'd5, 1'b0);
        wait_idle(20000);

        lat_dbl = 2; lat_add = 5;
        k = '0;
        k[252] = 1'b1;
        k[0] = 1'b1;
        launch(k, 1'b0);
        wait_idle(20000);

        lat_dbl = 2; lat_add = 3;
        {P_X, P_Y, P_Z, P_T} = {rand256(), rand256(), rand256(), rand256()};
        k = rand256();
        launch(k, 1'b0);
        wait_idle(20000);

        // A second start ten cycles into a busy operation must be dropped.
        lat_dbl = 3; lat_add = 2;
        done_before = n_done;
        launch(253'd5, 1'b0);
        repeat (9) @(negedge clk);
        scalar = ~scalar;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(20000);
        repeat (20) @(negedge clk);
        check("single_done", 255'(n_done - done_before), 255'(1));

        // Hung doubler trips the watchdog; R keeps the previous result.
        dbl_hang = 1'b1;
        launch(253'd5, 1'b1);
        wait_idle(2000);
        dbl_hang = 1'b0;
        repeat (5) @(negedge clk);

        // Reset mid-operation, followed by a stale add_done.
        lat_dbl = 2; lat_add = 2;
        launch(k, 1'b0);
        repeat (60) @(negedge clk);
        done_before = n_done;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sb.delete();
        last_r = '0;
        check("midrst_busy", 255'(busy), 255'(0));
        check("midrst_done", 255'(done), 255'(0));
        check("midrst_R_X", R_X, '0);
        check("midrst_R_T", R_T, '0);
        check("midrst_cycles", 255'(cycles), 255'(0));
        check("midrst_dbl_Y", dbl_Y, '0);
        check("midrst_add_P2_X", add_P2_X, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        stale_add = 1'b1;
        repeat (10) @(negedge clk);
        check("stale_no_done", 255'(n_done - done_before), 255'(0));
        check("stale_busy", 255'(busy), 255'(0));
        check("stale_R_X", R_X, '0);

        lat_dbl = 1; lat_add = 2;
        launch(253'd5, 1'b0);
        wait_idle(20000);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ed25519_scalar_mult_ctrl.md
# ed25519_scalar_mult_ctrl

Double-and-add sequencer that computes R = k·P by driving one external `ed25519_point_double` unit and one external `ed25519_point_add` unit through their start/done handshakes. It sits between the signing/keygen control logic and the point-operation datapath, replacing the single-shot scalar-mult unit with a bit-serial schedule. It also provides a per-operation watchdog and a busy-cycle counter.

## Interface
- `SCALAR_W`, 253: scalar width in bits, processed MSB first.
- `TIMEOUT`, 255: maximum cycles spent waiting for a unit `done` before the operation aborts.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `scalar`  in  SCALAR_W  scalar k; latched on accepted start.
- `P_X/P_Y/P_Z/P_T`  in  4×255  extended input point P; latched on accepted start.
- `busy`  out  1  high from the cycle after an accepted start until the done cycle (inclusive).
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `done` when the watchdog fired.
- `R_X/R_Y/R_Z/R_T`  out  4×255  result point; updated only on a successful `done`.
- `cycles`  out  32  number of busy cycles of the last operation; valid from `done`.
- `dbl_start`  out  1  one-cycle start to the doubler.
- `dbl_X/dbl_Y/dbl_Z/dbl_T`  out  4×255  doubler operand (the accumulator).
- `dbl_done`  in  1  doubler completion.
- `dbl_RX/dbl_RY/dbl_RZ/dbl_RT`  in  4×255  doubler result.
- `add_start`  out  1  one-cycle start to the adder.
- `add_P1_*/add_P2_*`  out  8×255  adder operands (P1 = accumulator, P2 = latched P).
- `add_done`  in  1  adder completion.
- `add_P3_*`  in  4×255  adder result.

## Operation
- States: IDLE, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT.
- IDLE + `start`: latch `scalar` and P, set acc = identity (0,1,1,0), set idx = SCALAR_W−1, clear `cycles` and the watchdog, go to DBL_REQ.
- DBL_REQ: assert `dbl_start` for one cycle, clear the watchdog, go to DBL_WAIT.
- DBL_WAIT on `dbl_done`: acc ← dbl result. Go to ADD_REQ if `scalar[idx]` = 1, else go to NEXT.
- ADD_REQ/ADD_WAIT behave the same way with the adder. On `add_done`: acc ← add result, then go to NEXT.
- NEXT: if idx = 0, copy R ← acc, pulse `done`, go to IDLE. Otherwise idx ← idx−1 and go to DBL_REQ.
- Operand outputs are driven from registers and stay stable from the REQ cycle through the done cycle.
- The watchdog counts WAIT cycles. When it reaches TIMEOUT with no `done` from the unit: pulse `done` + `err` together, leave R unchanged, go to IDLE.
- `dbl_done`/`add_done` are ignored outside their own WAIT state.
- `start` while busy is ignored; it is not queued.
- `cycles` increments every cycle in which `busy` = 1 and saturates at 2^32−1.
- Reset values: all outputs 0, including R = (0,0,0,0); state = IDLE.
- Reset mid-operation aborts immediately. No `done` is produced, and unit `done`s arriving after reset are ignored.

## Timing
- Accepted start at edge n → `busy` = 1 and DBL_REQ at n+1 → `dbl_start` visible during cycle n+1.
- Per doubling: 1 REQ cycle + L_dbl wait cycles (from `dbl_start` to `dbl_done` inclusive).
- Per addition: 1 + L_add cycles.
- Per bit: +1 cycle for NEXT.
- Total busy cycles = SCALAR_W·(2 + L_dbl) + popcount(k)·(1 + L_add).
- The result is captured in the `dbl_done`/`add_done` cycle and used as the operand in the next REQ cycle.

## Configuration
- `ED25519_SMUL_CONST_TIME_EN` defined: ADD_REQ/ADD_WAIT run for every bit regardless of the bit value.
  - The add result is written to acc only when `scalar[idx]` = 1; otherwise it is discarded.
  - Latency becomes SCALAR_W·(3 + L_dbl + L_add), independent of k.
- Undefined: the add is skipped for zero bits, giving the latency formula above.

## Test plan
- k = 0, macro off: expect 253 `dbl_start` pulses, 0 `add_start` pulses, then `done` with R = (0,1,1,0) and `err` = 0.
- k = 5 and k = 2^252+1 with the mock point units: `add_start` count equals popcount(k), R matches a bit-exact software model of the same unit sequence, and `cycles` matches the formula.
- `start` pulsed again at cycle 10 of a busy operation: ignored, result unchanged, exactly one `done`.
- Doubler stub that never asserts `dbl_done`, TIMEOUT = 255: `done` + `err` are asserted 256 cycles after `dbl_start`, R keeps its previous value, and `busy` = 0 the next cycle.
- `rst` asserted mid-operation, with a stale `add_done` one cycle after release: outputs are zero, no `done`, and a new start completes correctly.
- Macro on, k = 5: `add_start` count is 253, and R equals the macro-off result.
